mm_layer_table: RTL and testbench

- Model-manager-side responder for the DPR assignment stream. It receives the mm_o state codes, the asn_opcode values and the dpr_pass regions, and builds a per-layer descriptor table.
- It also captures the batch input/output sample regions.
- It exposes the table through a registered read port for the compute sequencer.
- It returns each captured region on mm_pass as an acknowledgement echo.

---
 rtl/mm_layer_table.sv | 198 +++++++++++++++++++
 tb/tb_mm_layer_table.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_layer_table.sv
// Model-manager responder: builds the per-layer descriptor table from the DPR assignment stream.
// Optional MM_REGION_CHECK_EN flags captured regions whose end lies below their begin.
module mm_layer_table #(
   parameter int ADDR_SIZE  = 23,
   parameter int MAX_LAYERS = 8,
   parameter int IDX_W      = 3
) (
   input  logic                 clk,
   input  logic                 rst_l,
   input  logic [3:0]           mm_o,
   input  logic [1:0]           asn_opcode,
   input  logic [ADDR_SIZE-1:0] dpr_pass_begin,
   input  logic [ADDR_SIZE-1:0] dpr_pass_end,
   output logic [ADDR_SIZE-1:0] mm_pass_begin,
   output logic [ADDR_SIZE-1:0] mm_pass_end,
   input  logic [IDX_W-1:0]     rd_idx,
   input  logic [2:0]           rd_field,
   output logic [ADDR_SIZE-1:0] rd_begin,
   output logic [ADDR_SIZE-1:0] rd_end,
   output logic [1:0]           rd_opcode,
   output logic [IDX_W:0]       num_layers,
   output logic                 model_valid,
   output logic [ADDR_SIZE-1:0] in_begin,
   output logic [ADDR_SIZE-1:0] in_end,
   output logic [ADDR_SIZE-1:0] out_begin,
   output logic [ADDR_SIZE-1:0] out_end,
   output logic                 batch_valid,
   output logic                 overflow,
   output logic                 region_err
);

   localparam logic [3:0] C_WAIT   = 4'd0;
   localparam logic [3:0] C_MODEL  = 4'd1;
   localparam logic [3:0] C_LAYER  = 4'd2;
   localparam logic [3:0] C_WEIGHT = 4'd3;
   localparam logic [3:0] C_SGRAD  = 4'd8;
   localparam logic [3:0] C_INPUT  = 4'd9;
   localparam logic [3:0] C_OUTPUT = 4'd10;
   localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_LAYERS);
   localparam logic [IDX_W:0] ONE_CNT = (IDX_W+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_BUILD, S_COMMIT} state_e;

   state_e               state_q, state_d;
   logic [3:0]           prev_code;
   logic [IDX_W:0]       count;
   logic [IDX_W:0]       cur_wide;
   logic [IDX_W-1:0]     cur;
   logic [2:0]           field_sel;
   logic                 region_cap, field_cap, layer_rise, bad_region;
   logic                 start_build, do_commit;
   logic                 in_flag, out_flag, region_err_q;

   logic [ADDR_SIZE-1:0] tbl_begin [MAX_LAYERS][6];
   logic [ADDR_SIZE-1:0] tbl_end   [MAX_LAYERS][6];
   logic [1:0]           opcode_q  [MAX_LAYERS];

   // The DPR presents region data one cycle after its code, so captures key off prev_code.
   assign region_cap = (prev_code >= C_WEIGHT) && (prev_code <= C_OUTPUT);
   assign field_cap  = (prev_code >= C_WEIGHT) && (prev_code <= C_SGRAD) &&
                       (count != '0) && !overflow;
   assign field_sel  = 3'(prev_code - C_WEIGHT);
   assign cur_wide   = count - ONE_CNT;
   assign cur        = cur_wide[IDX_W-1:0];
   assign layer_rise = (state_q == S_BUILD) && (mm_o == C_LAYER) && (prev_code != C_LAYER);

`ifdef MM_REGION_CHECK_EN
   assign bad_region = region_cap && (dpr_pass_end < dpr_pass_begin);
`else
   assign bad_region = 1'b0;
`endif

   assign region_err  = region_err_q;
   assign batch_valid = in_flag & out_flag;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      start_build = 1'b0;
      do_commit   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (mm_o == C_MODEL) begin
               state_d     = S_BUILD;
               start_build = 1'b1;
            end
         end
         S_BUILD: begin
            if (mm_o == C_WAIT && prev_code != C_WAIT) state_d = S_COMMIT;
         end
         S_COMMIT: begin
            do_commit = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the table is cleared by the async reset because downstream reads must see zeros after reset.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         prev_code     <= C_WAIT;
         count         <= '0;
         num_layers    <= '0;
         model_valid   <= 1'b0;
         overflow      <= 1'b0;
         region_err_q  <= 1'b0;
         mm_pass_begin <= '0;
         mm_pass_end   <= '0;
         in_begin      <= '0;
         in_end        <= '0;
         out_begin     <= '0;
         out_end       <= '0;
         in_flag       <= 1'b0;
         out_flag      <= 1'b0;
         for (int i = 0; i < MAX_LAYERS; i++) begin
            opcode_q[i] <= '0;
            for (int f = 0; f < 6; f++) begin
               tbl_begin[i][f] <= '0;
               tbl_end[i][f]   <= '0;
            end
         end
      end else begin
         prev_code <= mm_o;

         if (region_cap) begin
            mm_pass_begin <= dpr_pass_begin;
            mm_pass_end   <= dpr_pass_end;
         end
         if (field_cap) begin
            tbl_begin[cur][field_sel] <= dpr_pass_begin;
            tbl_end[cur][field_sel]   <= dpr_pass_end;
         end

         if (prev_code == C_INPUT) begin
            in_begin <= dpr_pass_begin;
            in_end   <= dpr_pass_end;
            in_flag  <= 1'b1;
            out_flag <= 1'b0;
         end
         if (prev_code == C_OUTPUT) begin
            out_begin <= dpr_pass_begin;
            out_end   <= dpr_pass_end;
            out_flag  <= 1'b1;
         end

         if (start_build) begin
            count        <= '0;
            model_valid  <= 1'b0;
            overflow     <= 1'b0;
            region_err_q <= 1'b0;
         end else begin
            if (bad_region) region_err_q <= 1'b1;
            if (layer_rise) begin
               if (count < MAX_CNT) begin
                  opcode_q[count[IDX_W-1:0]] <= asn_opcode;
                  count                      <= count + ONE_CNT;
               end else begin
                  overflow <= 1'b1;
               end
            end
         end

         if (do_commit) begin
            num_layers  <= count;
            model_valid <= !overflow && (count != '0) && !region_err_q;
         end
      end
   end

   // Registered read port; a same-edge table write is seen on the following read.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_begin  <= '0;
         rd_end    <= '0;
         rd_opcode <= '0;
      end else if ({1'b0, rd_idx} < MAX_CNT) begin
         rd_opcode <= opcode_q[rd_idx];
         if (rd_field <= 3'd5) begin
            rd_begin <= tbl_begin[rd_idx][rd_field];
            rd_end   <= tbl_end[rd_idx][rd_field];
         end else begin
            rd_begin <= '0;
            rd_end   <= '0;
         end
      end else begin
         rd_begin  <= '0;
         rd_end    <= '0;
         rd_opcode <= '0;
      end
   end

endmodule

// File: tb/tb_mm_layer_table.sv
// Directed testbench for mm_layer_table: layer build, overflow, batch regions, reset, region check.
`timescale 1ns/1ps
module tb_mm_layer_table;

   localparam int AW = 23;
   localparam logic [3:0] WAIT = 4'd0, MODEL = 4'd1, LAYER = 4'd2, WEIGHT = 4'd3,
                          WGRAD = 4'd4, BIAS = 4'd5, BGRAD = 4'd6, SCRATCH = 4'd7,
                          SGRAD = 4'd8, INPUT = 4'd9, OUTPUT = 4'd10;

   logic          clk = 1'b0;
   logic          rst_l = 1'b0;
   logic [3:0]    mm_o = '0;
   logic [1:0]    asn_opcode = '0;
   logic [AW-1:0] dpr_pass_begin = '0, dpr_pass_end = '0;
   logic [AW-1:0] mm_pass_begin, mm_pass_end;
   logic [2:0]    rd_idx = '0;
   logic [2:0]    rd_field = '0;
   logic [AW-1:0] rd_begin, rd_end;
   logic [1:0]    rd_opcode;
   logic [3:0]    num_layers;
   logic          model_valid;
   logic [AW-1:0] in_begin, in_end, out_begin, out_end;
   logic          batch_valid, overflow, region_err;

   logic [AW-1:0] pend_b = '0, pend_e = '0;
   int            n_checks = 0;
   int            n_fail = 0;

   mm_layer_table dut (
      .clk(clk), .rst_l(rst_l), .mm_o(mm_o), .asn_opcode(asn_opcode),
      .dpr_pass_begin(dpr_pass_begin), .dpr_pass_end(dpr_pass_end),
      .mm_pass_begin(mm_pass_begin), .mm_pass_end(mm_pass_end),
      .rd_idx(rd_idx), .rd_field(rd_field), .rd_begin(rd_begin), .rd_end(rd_end),
      .rd_opcode(rd_opcode), .num_layers(num_layers), .model_valid(model_valid),
      .in_begin(in_begin), .in_end(in_end), .out_begin(out_begin), .out_end(out_end),
      .batch_valid(batch_valid), .overflow(overflow), .region_err(region_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Announce a code; the region for the previous code rides along, as the DPR does.
   task automatic drive(input logic [3:0] code, input logic [1:0] op,
                        input logic [AW-1:0] nb, input logic [AW-1:0] ne);
      mm_o           = code;
      asn_opcode     = op;
      dpr_pass_begin = pend_b;
      dpr_pass_end   = pend_e;
      tick();
      pend_b = nb;
      pend_e = ne;
   endtask

   task automatic rd(input logic [2:0] idx, input logic [2:0] field);
      rd_idx   = idx;
      rd_field = field;
      tick();
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({model_valid, batch_valid, overflow, region_err, num_layers} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_flags: got %h expected 00",
                  {model_valid, batch_valid, overflow, region_err, num_layers});
      end
      n_checks++;
      if ({mm_pass_begin, rd_begin, in_begin} !== '0) begin
         n_fail++;
         $display("FAIL reset_regions: got %h/%h/%h expected 0", mm_pass_begin, rd_begin, in_begin);
      end
      tick();
      rst_l = 1'b1;
      tick();
   endtask

   task automatic test_single_layer();
      drive(MODEL, 2'd0, '0, '0);
      drive(LAYER, 2'd0, '0, '0);
      drive(WEIGHT, 2'd0, 23'h10, 23'h30);
      drive(WGRAD, 2'd0, 23'h100, 23'h120);
      drive(BIAS, 2'd0, 23'h30, 23'h36);
      drive(BGRAD, 2'd0, 23'h120, 23'h126);
      drive(SCRATCH, 2'd0, 23'h126, 23'h12C);
      drive(SGRAD, 2'd0, 23'h12C, 23'h132);
      drive(WAIT, 2'd0, '0, '0);
      drive(WAIT, 2'd0, '0, '0);
      n_checks++;
      if (num_layers !== 4'd1) begin
         n_fail++;
         $display("FAIL single_num_layers: got %0d expected 1", num_layers);
      end
      n_checks++;
      if (model_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_model_valid: got %b expected 1", model_valid);
      end
      n_checks++;
      if (mm_pass_begin !== 23'h12C || mm_pass_end !== 23'h132) begin
         n_fail++;
         $display("FAIL single_echo: got %h/%h expected 12c/132", mm_pass_begin, mm_pass_end);
      end
      rd(3'd0, 3'd2);
      n_checks++;
      if (rd_begin !== 23'h30 || rd_end !== 23'h36 || rd_opcode !== 2'd0) begin
         n_fail++;
         $display("FAIL single_rd_bias: got %h/%h op %0d expected 30/36 op 0",
                  rd_begin, rd_end, rd_opcode);
      end
      rd(3'd0, 3'd1);
      n_checks++;
      if (rd_begin !== 23'h100 || rd_end !== 23'h120) begin
         n_fail++;
         $display("FAIL single_rd_wgrad: got %h/%h expected 100/120", rd_begin, rd_end);
      end
      rd(3'd0, 3'd6);
      n_checks++;
      if (rd_begin !== '0 || rd_end !== '0) begin
         n_fail++;
         $display("FAIL rd_bad_field: got %h/%h expected 0/0", rd_begin, rd_end);
      end
   endtask

   task automatic test_three_layers();
      drive(MODEL, 2'd0, '0, '0);
      n_checks++;
      if (model_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rebuild_clears_valid: got %b expected 0", model_valid);
      end
      drive(LAYER, 2'd0, '0, '0);
      drive(WEIGHT, 2'd0, 23'h200, 23'h210);
      drive(SCRATCH, 2'd0, 23'h210, 23'h218);
      drive(LAYER, 2'd1, '0, '0);
      n_checks++;
      if (mm_pass_begin !== 23'h210 || mm_pass_end !== 23'h218) begin
         n_fail++;
         $display("FAIL three_echo_l0: got %h/%h expected 210/218", mm_pass_begin, mm_pass_end);
      end
      drive(SCRATCH, 2'd0, 23'h300, 23'h308);
      drive(SGRAD, 2'd0, 23'h308, 23'h310);
      drive(LAYER, 2'd2, '0, '0);
      drive(SCRATCH, 2'd0, 23'h400, 23'h404);
      drive(SGRAD, 2'd0, 23'h404, 23'h40C);
      drive(WAIT, 2'd0, '0, '0);
      n_checks++;
      if (mm_pass_begin !== 23'h404 || mm_pass_end !== 23'h40C) begin
         n_fail++;
         $display("FAIL three_echo_l2: got %h/%h expected 404/40c", mm_pass_begin, mm_pass_end);
      end
      drive(WAIT, 2'd0, '0, '0);
      n_checks++;
      if (num_layers !== 4'd3 || model_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL three_commit: got %0d/%b expected 3/1", num_layers, model_valid);
      end
      rd(3'd1, 3'd4);
      n_checks++;
      if (rd_begin !== 23'h300 || rd_end !== 23'h308 || rd_opcode !== 2'd1) begin
         n_fail++;
         $display("FAIL three_rd_l1: got %h/%h op %0d expected 300/308 op 1",
                  rd_begin, rd_end, rd_opcode);
      end
      rd(3'd2, 3'd4);
      n_checks++;
      if (rd_begin !== 23'h400 || rd_end !== 23'h404 || rd_opcode !== 2'd2) begin
         n_fail++;
         $display("FAIL three_rd_l2: got %h/%h op %0d expected 400/404 op 2",
                  rd_begin, rd_end, rd_opcode);
      end
      rd(3'd0, 3'd4);
      n_checks++;
      if (rd_begin !== 23'h210 || rd_end !== 23'h218) begin
         n_fail++;
         $display("FAIL three_rd_l0_simul: got %h/%h expected 210/218", rd_begin, rd_end);
      end
      rd(3'd1, 3'd5);
      n_checks++;
      if (rd_begin !== 23'h308 || rd_end !== 23'h310) begin
         n_fail++;
         $display("FAIL three_rd_l1_sgrad: got %h/%h expected 308/310", rd_begin, rd_end);
      end
   endtask

   task automatic test_overflow();
      drive(MODEL, 2'd0, '0, '0);
      for (int i = 0; i < 9; i++) begin
         drive(LAYER, 2'd3, '0, '0);
         drive(MODEL, 2'd0, '0, '0);
      end
      drive(WEIGHT, 2'd0, 23'h55, 23'h66);
      drive(WAIT, 2'd0, '0, '0);
      drive(WAIT, 2'd0, '0, '0);
      n_checks++;
      if (overflow !== 1'b1 || num_layers !== 4'd8 || model_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_commit: got ovf %b n %0d valid %b expected 1/8/0",
                  overflow, num_layers, model_valid);
      end
      rd(3'd7, 3'd0);
      n_checks++;
      if (rd_begin !== '0 || rd_end !== '0 || rd_opcode !== 2'd3) begin
         n_fail++;
         $display("FAIL overflow_dropped_write: got %h/%h op %0d expected 0/0 op 3",
                  rd_begin, rd_end, rd_opcode);
      end
   endtask

   task automatic test_batch();
      drive(INPUT, 2'd0, 23'h400000, 23'h400016);
      drive(OUTPUT, 2'd0, 23'h400016, 23'h400022);
      n_checks++;
      if (batch_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL batch_half: got %b expected 0", batch_valid);
      end
      drive(WAIT, 2'd0, '0, '0);
      n_checks++;
      if (batch_valid !== 1'b1 || in_begin !== 23'h400000 || in_end !== 23'h400016) begin
         n_fail++;
         $display("FAIL batch_input: got %b %h/%h expected 1 400000/400016",
                  batch_valid, in_begin, in_end);
      end
      n_checks++;
      if (out_begin !== 23'h400016 || out_end !== 23'h400022) begin
         n_fail++;
         $display("FAIL batch_output: got %h/%h expected 400016/400022", out_begin, out_end);
      end
      drive(INPUT, 2'd0, 23'h500000, 23'h500010);
      drive(WAIT, 2'd0, '0, '0);
      n_checks++;
      if (batch_valid !== 1'b0 || in_begin !== 23'h500000) begin
         n_fail++;
         $display("FAIL batch_reinput: got %b %h expected 0 500000", batch_valid, in_begin);
      end
   endtask

   task automatic test_reset_mid_build();
      drive(MODEL, 2'd0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         drive(LAYER, 2'd1, '0, '0);
         drive(WEIGHT, 2'd0, 23'h10, 23'h20);
      end
      rst_l = 1'b0;
      #1;
      n_checks++;
      if ({model_valid, batch_valid, overflow, num_layers} !== 7'h00) begin
         n_fail++;
         $display("FAIL midreset_flags: got %h expected 00",
                  {model_valid, batch_valid, overflow, num_layers});
      end
      n_checks++;
      if ({in_begin, out_begin, mm_pass_begin, rd_begin, rd_opcode} !== '0) begin
         n_fail++;
         $display("FAIL midreset_regions: got %h/%h/%h/%h expected 0",
                  in_begin, out_begin, mm_pass_begin, rd_begin);
      end
      mm_o   = WAIT;
      pend_b = '0;
      pend_e = '0;
      tick();
      rst_l = 1'b1;
      for (int i = 0; i < 3; i++) drive(WAIT, 2'd0, '0, '0);
      n_checks++;
      if (model_valid !== 1'b0 || num_layers !== 4'd0) begin
         n_fail++;
         $display("FAIL midreset_after: got %b/%0d expected 0/0", model_valid, num_layers);
      end
      rd(3'd0, 3'd0);
      n_checks++;
      if (rd_begin !== '0) begin
         n_fail++;
         $display("FAIL midreset_table: got %h expected 0", rd_begin);
      end
   endtask

   task automatic test_region_check();
      logic exp_err;
`ifdef MM_REGION_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      drive(MODEL, 2'd0, '0, '0);
      drive(LAYER, 2'd0, '0, '0);
      drive(WEIGHT, 2'd0, 23'h40, 23'h20);
      drive(WAIT, 2'd0, '0, '0);
      drive(WAIT, 2'd0, '0, '0);
      n_checks++;
      if (region_err !== exp_err || model_valid !== ~exp_err) begin
         n_fail++;
         $display("FAIL region_check: got err %b valid %b expected err %b valid %b",
                  region_err, model_valid, exp_err, ~exp_err);
      end
   endtask

   initial begin
      test_reset();
      test_single_layer();
      test_three_layers();
      test_overflow();
      test_batch();
      test_reset_mid_build();
      test_region_check();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
